// File: rtl/uart_cmd_rcv.sv
// uart_cmd_rcv: 8N1 UART receiver that assembles 3-byte command packets.
//
// A packet is {cmd, data[15:8], data[7:0]}, sent as three back-to-back bytes.
// The outputs update only when the third byte is received with a good stop bit.
// A partial packet is discarded after TMO_CLKS idle clocks.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   RX           asynchronous serial input, idle high, LSB first
//   clr_cmd_rdy  consumer acknowledge, clears cmd_rdy (a simultaneous set wins)
//   cmd          opcode of the last complete packet
//   data         payload of the last complete packet
//   cmd_rdy      a complete packet is held on cmd/data
//   frm_err      one-cycle pulse when a stop bit is sampled low
module uart_cmd_rcv #(
    parameter int unsigned BAUD_DIV = 2604,
    parameter int unsigned TMO_CLKS = 262144
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    input  logic        clr_cmd_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    output logic        frm_err
);

    localparam logic [15:0] BaudFull = 16'(BAUD_DIV);
    localparam logic [15:0] BaudHalf = 16'(BAUD_DIV / 2);
    localparam int unsigned TmoW     = $clog2(TMO_CLKS + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TMO_CLKS - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state;
    logic            rx_meta;
    logic            rx_s;
    logic            rx_prev;
    logic [15:0]     baud_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic [1:0]      byte_idx;
    logic [7:0]      cmd_sh;
    logic [7:0]      data_hi_sh;
    logic [TmoW-1:0] idle_cnt;

    logic baud_exp;
    logic start_det;
    logic byte_vld;

    always_comb begin
        // Loading N makes the counter expire N clocks later.
        baud_exp  = (baud_cnt == 16'd1);
        start_det = rx_prev && !rx_s;
        byte_vld  = (state == StStop) && baud_exp && rx_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            rx_prev    <= 1'b1;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            byte_idx   <= '0;
            cmd_sh     <= '0;
            data_hi_sh <= '0;
            idle_cnt   <= '0;
            cmd        <= 8'h00;
            data       <= 16'h0000;
            cmd_rdy    <= 1'b0;
            frm_err    <= 1'b0;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
            frm_err <= 1'b0;

            // Clear first; a packet completing in this same cycle overrides it below.
            if (clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
            end

            case (state)
                StIdle: begin
                    // rx_prev must be high, so a held-low line (break) never restarts.
                    if (start_det) begin
                        state    <= StStart;
                        baud_cnt <= BaudHalf;
                        idle_cnt <= '0;
                    end else if (byte_idx != 2'd0) begin
                        if (idle_cnt == TmoLast) begin
                            byte_idx <= '0;
                            idle_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end else begin
                        idle_cnt <= '0;
                    end
                end

                StStart: begin
                    if (baud_exp) begin
                        if (!rx_s) begin
                            state    <= StData;
                            baud_cnt <= BaudFull;
                            bit_cnt  <= '0;
                        end else begin
                            // Line went high again before mid-start: glitch.
                            state <= StIdle;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end

                StData: begin
                    if (baud_exp) begin
                        shift    <= {rx_s, shift[7:1]};
                        baud_cnt <= BaudFull;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= StStop;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end

                StStop: begin
                    if (baud_exp) begin
                        state    <= StIdle;
                        baud_cnt <= BaudFull;
                        if (byte_vld) begin
                            case (byte_idx)
                                2'd0: begin
                                    cmd_sh   <= shift;
                                    byte_idx <= 2'd1;
                                end
                                2'd1: begin
                                    data_hi_sh <= shift;
                                    byte_idx   <= 2'd2;
                                end
                                default: begin
                                    // All 24 output bits change together.
                                    cmd      <= cmd_sh;
                                    data     <= {data_hi_sh, shift};
                                    cmd_rdy  <= 1'b1;
                                    byte_idx <= 2'd0;
                                end
                            endcase
                        end else begin
                            frm_err  <= 1'b1;
                            byte_idx <= 2'd0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_rcv.sv
module tb_uart_cmd_rcv;

    localparam int unsigned BAUD = 16;
    localparam int unsigned TMO  = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        frm_err;

    uart_cmd_rcv #(
        .BAUD_DIV(BAUD),
        .TMO_CLKS(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RX         (RX),
        .clr_cmd_rdy(clr_cmd_rdy),
        .cmd        (cmd),
        .data       (data),
        .cmd_rdy    (cmd_rdy),
        .frm_err    (frm_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int ferr_cnt = 0;
    int set_seen_cnt = 0;

    // Outputs are observed on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (frm_err) ferr_cnt <= ferr_cnt + 1;
        if (clr_cmd_rdy && cmd_rdy) set_seen_cnt <= set_seen_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One 8N1 frame; optionally hold clr_cmd_rdy high across the stop bit.
    task automatic send_byte(input logic [7:0] b, input logic stop, input logic clr_stop);
        RX = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BAUD) @(negedge clk);
        end
        RX = stop;
        clr_cmd_rdy = clr_stop;
        repeat (BAUD) @(negedge clk);
        clr_cmd_rdy = 1'b0;
        RX = 1'b1;
        if (!stop) repeat (BAUD) @(negedge clk);
    endtask

    typedef struct {
        int          nb;
        logic [47:0] bytes;     // byte j at bits [8j+7:8j]
        logic [5:0]  stop_ok;
        int          gap_idx;   // insert idle gap after this byte (-1: none)
        int          gap;
        logic [7:0]  exp_cmd;
        logic [15:0] exp_data;
        int          exp_ferr;
    } vec_t;

    vec_t        vecs[4];
    logic [7:0]  prev_cmd;
    logic [15:0] prev_data;
    int          f0;
    int          s0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3, 48'h00_00_00_20_00_05, 6'b111111, -1, 0, 8'h05, 16'h0020, 0};
        vecs[1] = '{4, 48'h00_00_34_12_06_05, 6'b111110, -1, 0, 8'h06, 16'h1234, 1};
        vecs[2] = '{5, 48'h00_EF_BE_A5_00_05, 6'b111111, 1, 1100, 8'hA5, 16'hBEEF, 0};
        vecs[3] = '{3, 48'h00_00_00_5A_C3_3C, 6'b111111, -1, 0, 8'h3C, 16'hC35A, 0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_cmd", 32'(cmd), 32'h00);
        chk("reset_data", 32'(data), 32'h0000);
        chk("reset_rdy", 32'(cmd_rdy), 32'd0);
        chk("reset_ferr", 32'(frm_err), 32'd0);
        prev_cmd  = 8'h00;
        prev_data = 16'h0000;

        for (int i = 0; i < 4; i++) begin
            clr_cmd_rdy = 1'b1;
            @(negedge clk);
            clr_cmd_rdy = 1'b0;
            chk("clr_rdy", 32'(cmd_rdy), 32'd0);
            chk("clr_hold_cmd", 32'(cmd), 32'(prev_cmd));
            chk("clr_hold_data", 32'(data), 32'(prev_data));
            f0 = ferr_cnt;
            for (int j = 0; j < vecs[i].nb; j++) begin
                if (j == vecs[i].nb - 1) begin
                    chk("partial_rdy", 32'(cmd_rdy), 32'd0);
                    chk("partial_cmd", 32'(cmd), 32'(prev_cmd));
                    chk("partial_data", 32'(data), 32'(prev_data));
                end
                send_byte(vecs[i].bytes[8*j +: 8], vecs[i].stop_ok[j], 1'b0);
                if (j == vecs[i].gap_idx) repeat (vecs[i].gap) @(negedge clk);
            end
            chk("vec_rdy", 32'(cmd_rdy), 32'd1);
            chk("vec_cmd", 32'(cmd), 32'(vecs[i].exp_cmd));
            chk("vec_data", 32'(data), 32'(vecs[i].exp_data));
            chk("vec_ferr", 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
            prev_cmd  = vecs[i].exp_cmd;
            prev_data = vecs[i].exp_data;
        end

        // Short low glitch: rejected at mid-start, nothing reported.
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        f0 = ferr_cnt;
        RX = 1'b0;
        repeat (4) @(negedge clk);
        RX = 1'b1;
        repeat (3 * BAUD) @(negedge clk);
        chk("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
        chk("glitch_rdy", 32'(cmd_rdy), 32'd0);
        chk("glitch_cmd", 32'(cmd), 32'(prev_cmd));
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        send_byte(8'h33, 1'b1, 1'b0);
        chk("glitch_next_rdy", 32'(cmd_rdy), 32'd1);
        chk("glitch_next_cmd", 32'(cmd), 32'h11);
        chk("glitch_next_data", 32'(data), 32'h2233);

        // Break: one framing error only, then normal reception.
        f0 = ferr_cnt;
        RX = 1'b0;
        repeat (30 * BAUD) @(negedge clk);
        RX = 1'b1;
        repeat (3 * BAUD) @(negedge clk);
        chk("break_ferr", 32'(ferr_cnt - f0), 32'd1);
        send_byte(8'h44, 1'b1, 1'b0);
        send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'h66, 1'b1, 1'b0);
        chk("break_next_cmd", 32'(cmd), 32'h44);
        chk("break_next_data", 32'(data), 32'h5566);

        // Reset in the middle of the second byte.
        send_byte(8'h77, 1'b1, 1'b0);
        RX = 1'b0;
        repeat (BAUD) @(negedge clk);
        RX = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
        RX = 1'b0;
        repeat (BAUD) @(negedge clk);
        rst = 1'b1;
        RX = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * BAUD) @(negedge clk);
        chk("rst_mid_cmd", 32'(cmd), 32'h00);
        chk("rst_mid_data", 32'(data), 32'h0000);
        chk("rst_mid_rdy", 32'(cmd_rdy), 32'd0);

        // Third byte with clr_cmd_rdy held across its stop bit: set must win.
        s0 = set_seen_cnt;
        send_byte(8'h01, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, 1'b1);
        chk("set_wins", 32'(set_seen_cnt != s0), 32'd1);
        chk("rst_pkt_cmd", 32'(cmd), 32'h01);
        chk("rst_pkt_data", 32'(data), 32'hFF00);
        chk("clr_after_set", 32'(cmd_rdy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
